// File: rtl/counter_pkg.sv
// Shared defaults for the counter bank: channel width/count and the reset limit value.
package counter_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNch   = 4;
    localparam int unsigned MaxWidth = 16;

    // Limits reset to all-ones; channels slice the low WIDTH bits.
    localparam logic [MaxWidth-1:0] MaxLimit = '1;

    function automatic int unsigned sel_width(int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/counter_chan.sv
// One counter channel: count, limit and terminal-count pulse.
// Saturating boundary behaviour is only honoured when COUNTER_BANK_SAT_EN is defined.
module counter_chan
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             dir_up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic             limit_wr,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             tc_q, tc_d;
    logic             sat;
    logic             step;
    logic             at_bound;

`ifdef COUNTER_BANK_SAT_EN
    assign sat = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat             = 1'b0;
`endif

    // A load on this channel takes priority over stepping.
    assign step     = cnt_en & ~load;
    assign at_bound = dir_up ? (count_q >= limit_q) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        tc_d    = 1'b0;
        if (step) begin
            tc_d = at_bound;
            if (!at_bound) begin
                count_d = dir_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end else if (dir_up) begin
                count_d = sat ? limit_q : '0;
            end else begin
                count_d = sat ? '0 : limit_q;
            end
        end
        if (load) begin
            count_d = load_data;
        end
        if (limit_wr) begin
            limit_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= MaxLimit[WIDTH-1:0];
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with per-channel limit, load and terminal count.
// Define COUNTER_BANK_SAT_EN to enable per-channel saturation (sat_mode); otherwise all wrap.
module counter_bank
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NCH   = DefNch,
    localparam int unsigned SelW = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       cnt_en,
    input  logic [NCH-1:0]       dir_up,
    input  logic [NCH-1:0]       sat_mode,
    input  logic                 load,
    input  logic                 limit_wr,
    input  logic [SelW-1:0]      load_sel,
    input  logic [WIDTH-1:0]     load_data,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       tc
);

    logic [NCH-1:0] chan_load;
    logic [NCH-1:0] chan_limit_wr;
    int unsigned    sel_idx;

    // Out-of-range selects match no channel, so the write is dropped.
    always_comb begin
        sel_idx = 32'(load_sel);
        for (int unsigned k = 0; k < NCH; k++) begin
            chan_load[k]     = load & (sel_idx == k);
            chan_limit_wr[k] = limit_wr & (sel_idx == k);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt_en    (cnt_en[k]),
            .dir_up    (dir_up[k]),
            .sat_mode  (sat_mode[k]),
            .load      (chan_load[k]),
            .limit_wr  (chan_limit_wr[k]),
            .load_data (load_data),
            .count     (count[k*WIDTH +: WIDTH]),
            .tc        (tc[k])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: vector table, directed corner sequences, random vs model.
module tb_counter_bank;

    localparam int W = 8;
    localparam int N = 4;
`ifdef COUNTER_BANK_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   cnt_en, dir_up, sat_mode;
    logic           load, limit_wr;
    logic [1:0]     load_sel;
    logic [W-1:0]   load_data;
    logic [N*W-1:0] count;
    logic [N-1:0]   tc;

    // Second instance with NCH=3 so an out-of-range select is expressible.
    logic [2:0]     b_en, b_up, b_sat;
    logic           b_load, b_lw;
    logic [1:0]     b_sel;
    logic [W-1:0]   b_data;
    logic [3*W-1:0] b_count;
    logic [2:0]     b_tc;

    counter_bank #(.WIDTH(W), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .dir_up(dir_up), .sat_mode(sat_mode),
        .load(load), .limit_wr(limit_wr), .load_sel(load_sel), .load_data(load_data),
        .count(count), .tc(tc)
    );

    counter_bank #(.WIDTH(W), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cnt_en(b_en), .dir_up(b_up), .sat_mode(b_sat),
        .load(b_load), .limit_wr(b_lw), .load_sel(b_sel), .load_data(b_data),
        .count(b_count), .tc(b_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int m_cnt[N];
    int m_lim[N];
    bit m_tc[N];

    typedef struct {
        logic [3:0] en, up, sat;
        logic       ld, lw;
        logic [1:0] sel;
        logic [7:0] data;
        int         ch;
        logic [7:0] exp_cnt;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic [3:0] en, logic [3:0] up, logic [3:0] sat, logic ld,
                                logic lw, logic [1:0] sel, logic [7:0] data, int ch,
                                logic [7:0] ec, logic et);
        vec_t v;
        v.en = en; v.up = up; v.sat = sat; v.ld = ld; v.lw = lw; v.sel = sel; v.data = data;
        v.ch = ch; v.exp_cnt = ec; v.exp_tc = et;
        return v;
    endfunction

    task automatic expect_eq(string name, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            m_lim[k] = (1 << W) - 1;
            m_tc[k]  = 1'b0;
        end
    endfunction

    // Behavioural rules: range 0..limit, boundary handling, load priority, select decode.
    function automatic void model_update();
        for (int k = 0; k < N; k++) begin
            bit ld = load && (int'(load_sel) == k);
            bit lw = limit_wr && (int'(load_sel) == k);
            bit s  = SatEn && sat_mode[k];
            int c  = m_cnt[k];
            int l  = m_lim[k];
            bit t  = 1'b0;
            if (cnt_en[k] && !ld) begin
                if (dir_up[k]) begin
                    if (c < l) c = c + 1;
                    else begin t = 1'b1; c = s ? l : 0; end
                end else begin
                    if (c > 0) c = c - 1;
                    else begin t = 1'b1; c = s ? 0 : l; end
                end
            end
            if (ld) c = int'(load_data);
            if (lw) l = int'(load_data);
            m_cnt[k] = c;
            m_lim[k] = l;
            m_tc[k]  = t;
        end
    endfunction

    task automatic check_all(string tag);
        for (int k = 0; k < N; k++) begin
            expect_eq($sformatf("%s cnt%0d", tag, k), 16'(count[k*W +: W]), 16'(m_cnt[k]));
            expect_eq($sformatf("%s tc%0d", tag, k), 16'(tc[k]), 16'(m_tc[k]));
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
        check_all(tag);
    endtask

    task automatic drive(logic [3:0] en, logic [3:0] up, logic [3:0] sat, logic ld, logic lw,
                         logic [1:0] sel, logic [7:0] data);
        cnt_en = en; dir_up = up; sat_mode = sat;
        load = ld; limit_wr = lw; load_sel = sel; load_data = data;
    endtask

    task automatic expect_ch(string name, int ch, int ec, int et);
        expect_eq({name, " count"}, 16'(count[ch*W +: W]), 16'(ec));
        expect_eq({name, " tc"}, 16'(tc[ch]), 16'(et));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        b_en = 0; b_up = 0; b_sat = 0; b_load = 0; b_lw = 0; b_sel = 0; b_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Limit 5 wrap on ch1, load-above-limit on ch2, combined load+limit on ch3.
        tbl[0]  = mk(4'b0000, 4'b0000, 0, 0, 1, 1, 5, 1, 0, 0);
        tbl[1]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[2]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 2, 0);
        tbl[3]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 3, 0);
        tbl[4]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 4, 0);
        tbl[5]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 5, 0);
        tbl[6]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[7]  = mk(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[8]  = mk(4'b0000, 4'b0000, 0, 0, 1, 2, 10, 2, 0, 0);
        tbl[9]  = mk(4'b0000, 4'b0000, 0, 1, 0, 2, 20, 2, 20, 0);
        tbl[10] = mk(4'b0100, 4'b0100, 0, 0, 0, 0, 0, 2, 0, 1);
        tbl[11] = mk(4'b0000, 4'b0000, 0, 1, 1, 3, 7, 3, 7, 0);
        tbl[12] = mk(4'b1000, 4'b1000, 0, 0, 0, 0, 0, 3, 0, 1);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].ld, tbl[i].lw, tbl[i].sel,
                  tbl[i].data);
            cycle($sformatf("tbl%0d", i));
            expect_ch($sformatf("tbl%0d ch%0d", i, tbl[i].ch), tbl[i].ch,
                      int'(tbl[i].exp_cnt), int'(tbl[i].exp_tc));
        end

        // ch0 full-range wrap at the reset limit of 255.
        drive(4'b0001, 4'b0001, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 257; i++) begin
            cycle("wrap255");
            if (i == 255) expect_ch("wrap255 at255", 0, 255, 0);
            if (i == 256) expect_ch("wrap255 at0", 0, 0, 1);
            if (i == 257) expect_ch("wrap255 at1", 0, 1, 0);
        end

        // ch2 down from 0: saturate holds at 0, wrap goes to limit.
        drive(0, 0, 0, 0, 1, 2, 255);
        cycle("ch2 lim");
        drive(0, 0, 0, 1, 0, 2, 0);
        cycle("ch2 ld0");
        drive(4'b0100, 4'b0000, 4'b0100, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("down");
            if (SatEn) expect_ch($sformatf("down sat%0d", i), 2, 0, 1);
            else expect_ch($sformatf("down wrap%0d", i), 2, 255 - i, (i == 0) ? 1 : 0);
        end

        // Load ch3 while others count.
        drive(4'b0111, 4'b0111, 0, 1, 0, 3, 200);
        cycle("ld ch3");
        expect_ch("ld ch3", 3, 200, 0);

        // Lowering the limit below the count leaves count alone until a step.
        drive(0, 0, 0, 1, 0, 1, 4);
        cycle("ch1 ld4");
        drive(0, 0, 0, 0, 1, 1, 2);
        cycle("ch1 lim2");
        expect_ch("ch1 lim2 hold", 1, 4, 0);
        drive(4'b0010, 4'b0010, 0, 0, 0, 0, 0);
        cycle("ch1 step");
        expect_ch("ch1 over-limit step", 1, 0, 1);

        // Asynchronous reset mid-count; a load pending during reset is discarded.
        drive(0, 0, 0, 1, 0, 0, 37);
        cycle("ld37");
        expect_ch("ld37", 0, 37, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        expect_ch("async rst", 0, 0, 0);
        check_all("async rst");
        drive(4'b1111, 4'b1111, 0, 1, 1, 0, 99);
        cycle("rst hold");
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 3, 254);
        cycle("post rst ld");
        drive(4'b1000, 4'b1000, 0, 0, 0, 0, 0);
        cycle("post rst step");
        expect_ch("limit reset 255", 3, 255, 0);
        cycle("post rst wrap");
        expect_ch("limit reset wrap", 3, 0, 1);

        // Random traffic against the model, biased toward small limits and loads.
        for (int i = 0; i < 400; i++) begin
            cnt_en    = N'($urandom);
            dir_up    = N'($urandom);
            sat_mode  = N'($urandom);
            load      = ($urandom_range(0, 7) == 0);
            limit_wr  = ($urandom_range(0, 5) == 0);
            load_sel  = 2'($urandom);
            load_data = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15))
                                                     : W'($urandom_range(0, 255));
            cycle($sformatf("rnd%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // Out-of-range select on the NCH=3 instance: load and limit_wr both dropped.
        b_en = 3'b111; b_up = 3'b111; b_load = 1; b_lw = 1; b_sel = 2'd3; b_data = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            expect_eq($sformatf("badsel cnt%0d", k), 16'(b_count[k*W +: W]), 16'd1);
        end
        b_en = 0; b_data = 99;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            expect_eq($sformatf("badsel hold%0d", k), 16'(b_count[k*W +: W]), 16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
